// File: rtl/alu_arb.sv
// ============================================================================
// alu_arb : round-robin arbiter/sequencer sharing one combinational ALU
//           between two valid/ready requesters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arb #(
  parameter int XLEN = 64,
  parameter int SELW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic [SELW-1:0] req0_sel,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic [SELW-1:0] req1_sel,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [SELW-1:0] alu_sel,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            owner;
  logic            grant;
  logic            req_fire;
  logic            rsp_fire;
  logic [XLEN-1:0] op1_q, op2_q, res_q;
  logic [SELW-1:0] sel_q;
  logic            zero_q;

  always_comb begin
    // On a tie the requester that did not win last time gets the grant.
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req_fire   = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = req_fire && !grant;
    req1_ready = req_fire && grant;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
    rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    state_nxt  = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      sel_q      <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      if (req_fire) begin
        owner      <= grant;
        last_grant <= grant;
        op1_q      <= grant ? req1_op1 : req0_op1;
        op2_q      <= grant ? req1_op2 : req0_op2;
        sel_q      <= grant ? req1_sel : req0_sel;
      end
      if (state == EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_op1     = op1_q;
  assign alu_op2     = op2_q;
  assign alu_sel     = sel_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arb.sv
// ============================================================================
// tb_alu_arb : directed self-checking bench for alu_arb with a small ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
  logic [3:0]  req0_sel = 0, req1_sel = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [63:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [63:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_sel;
  logic        alu_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Reference ALU: AND, OR, ADD, SUB; other codes yield 0.
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 64'd0);
  end

  alu_arb #(.XLEN(64), .SELW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held from time 0, idle inputs.
    tick();
    tick();
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_zero", rsp1_zero, 0);
    chk("rst_alu_op1", alu_op1, 0);
    chk("rst_alu_sel", alu_sel, 0);

    // Single add on req0.
    rst = 0;
    req0_valid = 1; req0_op1 = 5; req0_op2 = 3; req0_sel = 4'b0010;
    #1;
    chk("first_req0_ready", req0_ready, 1);
    chk("first_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("exec_req0_ready", req0_ready, 0);
    chk("exec_rsp0_valid", rsp0_valid, 0);
    chk("exec_alu_sel", alu_sel, 4'b0010);
    chk("exec_alu_op1", alu_op1, 5);
    tick();
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_rsp0_result", rsp0_result, 8);
    chk("add_rsp0_zero", rsp0_zero, 0);
    chk("add_rsp1_valid", rsp1_valid, 0);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    chk("add_back_idle", rsp0_valid, 0);

    // Zero flag via subtract on req1.
    req1_valid = 1; req1_op1 = 7; req1_op2 = 7; req1_sel = 4'b0110;
    #1;
    chk("sub_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("sub_rsp1_valid", rsp1_valid, 1);
    chk("sub_rsp0_valid", rsp0_valid, 0);
    chk("sub_rsp1_result", rsp1_result, 0);
    chk("sub_rsp1_zero", rsp1_zero, 1);
    rsp1_ready = 1;
    tick();

    // OR on req1 (granted although it was also last grant).
    req1_valid = 1; req1_op1 = 64'hF0; req1_op2 = 64'h0F; req1_sel = 4'b0001;
    #1;
    chk("or_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    chk("or_rsp1_result", rsp1_result, 64'hFF);
    chk("or_rsp1_zero", rsp1_zero, 0);
    tick();

    // Contention with immediate response acceptance: grants alternate 0,1,...
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op1 = 10;  req0_op2 = 20; req0_sel = 4'b0010;
    req1_valid = 1; req1_op1 = 100; req1_op2 = 1;  req1_sel = 4'b0110;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_req0_ready", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_req1_ready", req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      tick();
      chk("rr_rsp0_valid", rsp0_valid, (k % 2 == 0) ? 1 : 0);
      chk("rr_rsp1_valid", rsp1_valid, (k % 2 == 1) ? 1 : 0);
      chk("rr_result", rsp0_result, (k % 2 == 0) ? 64'd30 : 64'd99);
      tick();
    end

    // Backpressure on req0 blocks req1.
    rsp0_ready = 0;
    req0_op1 = 5; req0_op2 = 3;
    #1;
    chk("bp_req0_ready", req0_ready, 1);
    tick();
    req0_valid = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp0_valid", rsp0_valid, 1);
      chk("bp_rsp0_result", rsp0_result, 8);
      chk("bp_req1_ready", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1;
    tick();
    chk("bp_release_req1_ready", req1_ready, 1);

    // Reset during req1 execute drops the operation.
    tick();
    chk("mid_exec_rsp1_valid", rsp1_valid, 0);
    req1_valid = 0;
    rst = 1;
    #1;
    chk("mid_rst_req1_ready", req1_ready, 0);
    chk("mid_rst_alu_op1", alu_op1, 0);
    tick();
    tick();
    chk("mid_rst_rsp1_valid", rsp1_valid, 0);
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_req0_ready", req0_ready, 1);
    chk("post_rst_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("post_rst_rsp0_valid", rsp0_valid, 1);
    chk("post_rst_rsp1_valid", rsp1_valid, 0);
    chk("post_rst_result", rsp0_result, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_arb.md
# alu_arb

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters, e.g. the execute stage and the branch/address unit. Each requester issues an operation over a valid/ready request channel and receives the result and zero flag over a valid/ready response channel. The block latches operands, drives the ALU for one cycle, captures the result, and holds it until the owning requester accepts it. It sits between the requesters and the ALU and is the only driver of the ALU inputs.

## Interface
- XLEN, 64, operand/result width
- SELW, 4, ALU select width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- reqN_valid  input  1  requester N (N=0,1) has an operation
- reqN_ready  output  1  arbiter accepts requester N's operation this cycle
- reqN_op1, reqN_op2  input  XLEN  operands
- reqN_sel  input  SELW  ALU select code, passed through unmodified
- rspN_valid  output  1  result for requester N available
- rspN_ready  input  1  requester N accepts result
- rspN_result  output  XLEN  result
- rspN_zero  output  1  zero flag
- alu_op1, alu_op2  output  XLEN  to ALU
- alu_sel  output  SELW  to ALU
- alu_result  input  XLEN  from ALU
- alu_zero  input  1  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one requester. Only the granted reqN_ready is high, combinationally. Handshake is valid&ready. On handshake, latch op1/op2/sel and owner id into registers, then go to EXEC. If no requester is valid, stay in IDLE with both ready low.
- Arbitration is round-robin on a last_grant bit. If both requesters are valid, grant the one that is not last_grant. If one is valid, grant it regardless of last_grant. Update last_grant on the request handshake.
- EXEC: alu_op1/alu_op2/alu_sel are driven from the latched registers, which they always are. Capture alu_result and alu_zero into the result registers at the end of the cycle. Go to RESP.
- RESP: rsp_valid is high for the owner only, and result/zero are driven from the captured registers on both rspN buses. On rsp handshake, go to IDLE. A new request is not accepted in the same cycle.
- Both reqN_ready are low in EXEC and RESP. A stalled response blocks the other requester.
- Requesters must hold valid and operands stable until ready. Dropping valid early is a protocol violation and is not checked.
- The latched sel code is not decoded. Undefined codes pass through, and the ALU default behaviour applies.

## Timing
- Reset values: state IDLE; all reqN_ready and rspN_valid 0; rspN_result 0; rspN_zero 0; alu_op1, alu_op2 and alu_sel 0; last_grant 1, so req0 wins the first tie.
- Latency: request handshake at edge T, then EXEC during cycle T→T+1, then rsp_valid high from edge T+1. So rsp_valid rises one cycle after accept.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with immediate rsp_ready).
- rsp_valid and result stay stable while rsp_ready is low, for any duration.
- Reset asserted in any state returns to IDLE immediately. The in-flight operation is dropped, no response is produced, and last_grant returns to 1.
- Same-cycle valid on both requesters in IDLE: exactly one ready is asserted, never both.

## Test plan
- Reset: assert rst mid-idle → all outputs 0, both ready 0. After release with req0_valid=1, req0_ready=1 in the first cycle.
- Single add: req0 op1=5, op2=3, sel=4'b0010 → one cycle after accept, rsp0_valid=1, rsp0_result=8, rsp0_zero=0, rsp1_valid=0.
- Zero flag: req1 op1=7, op2=7, sel=4'b0110 → rsp1_result=0, rsp1_zero=1. Then req1 sel=4'b0001 with 0xF0 and 0x0F → result 0xFF, zero=0.
- Contention: both valid continuously with rsp_ready=1 → grant order 0,1,0,1,… and an accept every 3 cycles. Each response matches its own operands.
- Backpressure: rsp0_ready held low for 5 cycles → rsp0_valid and result stable, req1_ready stays 0 despite req1_valid=1. On release, req1 is accepted in the next cycle.
- Reset mid-op: assert rst during EXEC for req1 → no rsp1_valid. After release with both valid, req0 is granted first.
